lu_pipe: RTL

Registered, parametrised logic unit. It applies one of the eight two-input bitwise functions, selected per transaction, to WIDTH-bit operands. An internal accumulator can replace operand A, so operations can be chained across transactions. Input and output use valid/ready handshakes, and a saturating counter tracks delivered results. It sits between an operand source and a result consumer and generalises the single-bit gate set and 2:1 select into one pipelined, back-pressurable stage.

---
 rtl/lu_pipe.sv | 78 +++++++
 1 files changed

// File: rtl/lu_pipe.sv
// Registered WIDTH-bit logic unit: one of eight bitwise functions per transaction,
// optional accumulator operand, valid/ready on both sides, saturating delivery count.
module lu_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] res;
  logic             accept;
  logic             deliver;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  // acc_clr only matters when the accumulator is the selected operand
  always_comb begin
    opa = a;
    if (acc) opa = acc_clr ? '0 : acc_q;
  end

  always_comb begin
    res = '0;
    case (op)
      3'd0: res = ~(opa ^ b);
      3'd1: res = opa | b;
      3'd2: res = opa ^ b;
      3'd3: res = ~(opa | b);
      3'd4: res = opa & b;
      3'd5: res = ~(opa & b);
      3'd6: res = ~opa;
      3'd7: res = ~b;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s         <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      acc_q     <= '0;
    end else if (accept) begin
      s         <= res;
      zero      <= (res == '0);
      out_valid <= 1'b1;
      acc_q     <= res;
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (deliver && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
